alu8_issue: RTL and testbench

Command issuer and result collector for the ALU8 datapath. It accepts operand/mode commands over a valid/ready handshake and drives registered `left`/`right`/`mode` into a combinational ALU8 instance. After the ALU settles it captures `ALUout` and presents it, with a sequence tag, on a valid/ready result port. It sits between the control sequencer and the ALU8 datapath, so ALU8 never sees unregistered operands.

---
 rtl/alu8_issue.sv | 111 +++++++++++
 tb/tb_alu8_issue.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_issue.sv
// Registered command issuer and result collector around a combinational ALU8.
// Define ALU_SEQ_CHAIN_EN to let a command reuse the last handed-off result.
module alu8_issue #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_left,
  input  logic [7:0]       cmd_right,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_chain,
  output logic [7:0]       alu_left,
  output logic [7:0]       alu_right,
  output logic [1:0]       alu_mode,
  input  logic [7:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [TAG_W-1:0] res_tag
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             settle;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] cur_tag;
  logic [7:0]       left_sel;
  logic             accept;
  logic             capture;
  logic             handoff;

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = cmd_ready & cmd_valid;
  assign capture   = (state == EXEC) & settle;
  assign handoff   = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = EXEC;
      EXEC:    if (settle)    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_SEQ_CHAIN_EN
  logic [7:0] last_res;
  logic       chain_vld;

  assign left_sel = (cmd_chain && chain_vld) ? last_res : cmd_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_res  <= 8'h00;
      chain_vld <= 1'b0;
    end else if (handoff) begin
      last_res  <= res_data;
      chain_vld <= 1'b1;
    end
  end
`else
  logic unused_chain;

  assign left_sel     = cmd_left;
  assign unused_chain = cmd_chain;
`endif

  // settle gives the ALU one cycle after the operand load before the
  // full stable cycle that ends in capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle    <= 1'b0;
      tag_cnt   <= '0;
      cur_tag   <= '0;
      alu_left  <= 8'h00;
      alu_right <= 8'h00;
      alu_mode  <= 2'd0;
      res_data  <= 8'h00;
      res_tag   <= '0;
    end else begin
      settle <= (state == EXEC) & ~settle;
      if (accept) begin
        alu_left  <= left_sel;
        alu_right <= cmd_right;
        alu_mode  <= cmd_mode;
        cur_tag   <= tag_cnt;
        tag_cnt   <= tag_cnt + 1'b1;
      end
      if (capture) begin
        res_data <= alu_out;
        res_tag  <= cur_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu8_issue.sv
// Directed self-checking bench for alu8_issue with a behavioural ALU8 model.
// Expected chain result depends on ALU_SEQ_CHAIN_EN.
module tb_alu8_issue;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_left;
  logic [7:0]       cmd_right;
  logic [1:0]       cmd_mode;
  logic             cmd_chain;
  logic [7:0]       alu_left;
  logic [7:0]       alu_right;
  logic [1:0]       alu_mode;
  logic [7:0]       alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [TAG_W-1:0] res_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu8_issue #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_left  (cmd_left),
    .cmd_right (cmd_right),
    .cmd_mode  (cmd_mode),
    .cmd_chain (cmd_chain),
    .alu_left  (alu_left),
    .alu_right (alu_right),
    .alu_mode  (alu_mode),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag)
  );

  // ALU8: nibble operands zero-extended, 8-bit wrapping arithmetic
  logic [7:0] na, nb;
  always_comb begin
    na = {4'h0, alu_left[3:0]};
    nb = {4'h0, alu_right[3:0]};
    alu_out = 8'h00;
    case (alu_mode)
      2'd0: alu_out = na + nb;
      2'd1: alu_out = na - nb;
      2'd2: alu_out = na & nb;
      default: alu_out = na | nb;
    endcase
  end

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one command from a negedge and waits (bounded) for its result,
  // returning at the negedge after the handshake when res_ready is high.
  task automatic run_cmd(input logic [7:0] l, input logic [7:0] r,
                         input logic [1:0] m, input logic ch,
                         output logic [7:0] d, output logic [TAG_W-1:0] t,
                         output bit ok);
    int k;
    ok = 1'b0;
    d = 8'h00;
    t = '0;
    cmd_valid = 1'b1;
    cmd_left = l;
    cmd_right = r;
    cmd_mode = m;
    cmd_chain = ch;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    k = 0;
    while (!ok && k < 10) begin
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        d = res_data;
        t = res_tag;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (ok && res_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    res_ready = 1'b1;
    cmd_left = 8'h5A;
    cmd_right = 8'hA5;
    cmd_mode = 2'd3;
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_chain = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_res_valid: got %b want 0", res_valid);
    end
    checks++;
    if ({res_data, res_tag} !== 12'h000) begin
      errors++;
      $display("FAIL reset_res: got data %h tag %h want 00 0", res_data, res_tag);
    end
    checks++;
    if ({alu_left, alu_right, alu_mode} !== 18'h0) begin
      errors++;
      $display("FAIL reset_alu: got %h %h %h want 00 00 0",
               alu_left, alu_right, alu_mode);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_left = 8'h30;
    cmd_right = 8'h0B;
    cmd_mode = 2'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (alu_left !== 8'h30 || alu_right !== 8'h0B || alu_mode !== 2'd0) begin
      errors++;
      $display("FAIL lat_operands: got %h %h %h want 30 0b 0",
               alu_left, alu_right, alu_mode);
    end
    checks++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_n1: got ready %b valid %b want 0 0", cmd_ready, res_valid);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_n2_valid: got %b want 0", res_valid);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_n3: got valid %b ready %b want 1 0", res_valid, cmd_ready);
    end
    checks++;
    if (res_data !== 8'h0B || res_tag !== 4'd0) begin
      errors++;
      $display("FAIL lat_result: got %h tag %h want 0b tag 0", res_data, res_tag);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_return: got valid %b ready %b want 0 1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_modes();
    logic [7:0] d;
    logic [TAG_W-1:0] t;
    bit ok;
    run_cmd(8'h03, 8'h05, 2'd1, 1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 8'hFE || t !== 4'd1) begin
      errors++;
      $display("FAIL mode_sub: got %h tag %h ok %b want fe tag 1", d, t, ok);
    end
    run_cmd(8'hFC, 8'h0A, 2'd2, 1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 8'h08 || t !== 4'd2) begin
      errors++;
      $display("FAIL mode_and: got %h tag %h ok %b want 08 tag 2", d, t, ok);
    end
    run_cmd(8'h01, 8'h0A, 2'd3, 1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 8'h0B || t !== 4'd3) begin
      errors++;
      $display("FAIL mode_or: got %h tag %h ok %b want 0b tag 3", d, t, ok);
    end
  endtask

  task automatic test_stall();
    logic [7:0] d;
    logic [TAG_W-1:0] t;
    bit ok;
    res_ready = 1'b0;
    run_cmd(8'h07, 8'h02, 2'd0, 1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 8'h09 || t !== 4'd4) begin
      errors++;
      $display("FAIL stall_first: got %h tag %h ok %b want 09 tag 4", d, t, ok);
    end
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      cmd_left = 8'hAA;
      cmd_right = 8'h55;
      cmd_mode = 2'd1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_data !== 8'h09 ||
          res_tag !== 4'd4 || alu_left !== 8'h07) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid %b ready %b data %h tag %h left %h want 1 0 09 4 07",
                 i, res_valid, cmd_ready, res_data, res_tag, alu_left);
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got valid %b ready %b want 0 1", res_valid, cmd_ready);
    end
    run_cmd(8'h02, 8'h02, 2'd0, 1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 8'h04 || t !== 4'd5) begin
      errors++;
      $display("FAIL stall_tag_after: got %h tag %h ok %b want 04 tag 5", d, t, ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [TAG_W-1:0] t;
    logic [7:0] exp_d;
    bit ok;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_d = 8'((i % 16) + ((i + 3) % 16));
      run_cmd(8'(i), 8'(i + 3), 2'd0, 1'b0, d, t, ok);
      checks++;
      if (!ok || d !== exp_d || t !== 4'(i % 16)) begin
        errors++;
        $display("FAIL b2b_%0d: got %h tag %h ok %b want %h tag %h",
                 i, d, t, ok, exp_d, 4'(i % 16));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [TAG_W-1:0] t;
    bit ok;
    bit seen;
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_left = 8'h0F;
    cmd_right = 8'h0F;
    cmd_mode = 2'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_tag !== 4'd0 ||
        alu_left !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_state: got valid %b ready %b tag %h left %h want 0 1 0 00",
               res_valid, cmd_ready, res_tag, alu_left);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_result: got %b want 0", seen);
    end
    run_cmd(8'h01, 8'h01, 2'd0, 1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 8'h02 || t !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_tag: got %h tag %h ok %b want 02 tag 0", d, t, ok);
    end
  endtask

  task automatic test_chain();
    logic [7:0] d;
    logic [TAG_W-1:0] t;
    logic [7:0] exp_d;
    bit ok;
    do_reset();
    res_ready = 1'b1;
    run_cmd(8'hFF, 8'h01, 2'd0, 1'b1, d, t, ok);
    checks++;
    if (!ok || d !== 8'h10) begin
      errors++;
      $display("FAIL chain_before_result: got %h ok %b want 10", d, ok);
    end
    do_reset();
    run_cmd(8'h05, 8'h03, 2'd0, 1'b0, d, t, ok);
    checks++;
    if (!ok || d !== 8'h08) begin
      errors++;
      $display("FAIL chain_first: got %h ok %b want 08", d, ok);
    end
`ifdef ALU_SEQ_CHAIN_EN
    exp_d = 8'h09;
`else
    exp_d = 8'h10;
`endif
    run_cmd(8'hFF, 8'h01, 2'd0, 1'b1, d, t, ok);
    checks++;
    if (!ok || d !== exp_d) begin
      errors++;
      $display("FAIL chain_second: got %h ok %b want %h", d, ok, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
